// File: rtl/dm_bytectl_if.sv
// Request/response bus of the dm_bytectl data memory: one request per cycle in,
// one registered response per accepted request out.
interface dm_bytectl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_adel;
    logic        rsp_ades;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_adel, rsp_ades
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_adel, rsp_ades
    );
endinterface

// File: rtl/dm_bytectl.sv
// MEM-stage data memory with byte/half/word access, registered loads, AdEL/AdES
// detection and a post-reset zeroing sweep. Optional store trace: DM_TRACE_EN.
module dm_bytectl #(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic         clk,
    input  logic         reset,
    dm_bytectl_if.slave  bus,
    output logic         init_busy
);

    // Byte span of the array, wide enough that DEPTH_WORDS*4 cannot overflow.
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) * 34'd4;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               ready;
    logic               clr_we;

    logic [31:0]        off;
    logic               misal, oor, fault, acc, st_we;
    logic [IDX_W-1:0]   word_idx;
    logic [3:0]         mask;
    logic [31:0]        old_word, merged;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               vld_p1, adel_p1, ades_p1;
    logic [31:0]        rdata_p1;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [3:0] m);
        logic [31:0] rep;
        logic [31:0] res;
        case (size)
            2'b00:   rep = {4{wdata[7:0]}};
            2'b01:   rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = m[i] ? rep[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   load_ext = sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   load_ext = sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Sweep/run controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH_WORDS - 1))
                    state_d = RUN;
            end
            RUN: ready = 1'b1;
            default: state_d = CLEAR;
        endcase
    end

    assign bus.req_ready = ready;

    // Request decode: alignment, range, lane selection and store merge
    assign off      = bus.req_addr - BASE_ADDR;
    assign misal    = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign oor      = (bus.req_addr < BASE_ADDR) || ({2'b00, off} >= LIMIT);
    assign fault    = misal || oor;
    assign acc      = bus.req_valid && ready;
    assign st_we    = acc && bus.req_we && !fault;
    assign word_idx = off[IDX_W+1:2];
    assign mask     = lane_mask(bus.req_size, off[1:0]);
    assign old_word = mem[word_idx];
    assign merged   = merge_word(old_word, bus.req_wdata, bus.req_size, mask);

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[cnt_q] <= '0;
        else if (st_we)
            mem[word_idx] <= merged;
    end

    // Response stage (_p1): one pulse per accepted request, zeroed when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
            adel_p1  <= 1'b0;
            ades_p1  <= 1'b0;
        end else if (acc) begin
            vld_p1   <= 1'b1;
            rdata_p1 <= (bus.req_we || fault) ? 32'h0
                        : load_ext(old_word, bus.req_size, off[1:0], bus.req_signed);
            adel_p1  <= fault && !bus.req_we;
            ades_p1  <= fault && bus.req_we;
        end else begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
            adel_p1  <= 1'b0;
            ades_p1  <= 1'b0;
        end
    end

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_rdata = rdata_p1;
    assign bus.rsp_adel  = adel_p1;
    assign bus.rsp_ades  = ades_p1;

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (st_we)
            $display("@%h: *%h <= %h", bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.req_pc;
`endif

endmodule

// File: tb/tb_dm_bytectl.sv
// Directed bench for dm_bytectl (DEPTH_WORDS=16, BASE_ADDR=0) with
// immediate-assertion checks after each response edge.
module tb_dm_bytectl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init_busy;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    dm_bytectl_if bus();

    dm_bytectl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, let it be accepted at the next edge, then sample just after.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_pc     = 32'h0040_0000 + addr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep(input string tag);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, 16);
        chk({tag, "_busy"}, init_busy, 0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_pc     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_busy",  init_busy, 1);
        chk("rst_ready", bus.req_ready, 0);
        reset = 1'b1;
        count_sweep("sweep1");

        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
            chk("clr_valid", bus.rsp_valid, 1);
            chk("clr_rdata", bus.rsp_rdata, 32'h0);
        end

        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344);
        chk("sw_ack",   bus.rsp_valid, 1);
        chk("sw_rdata", bus.rsp_rdata, 0);
        chk("sw_ades",  bus.rsp_ades, 0);
        issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB);
        issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        chk("lb_s", bus.rsp_rdata, 32'hFFFF_FFAB);
        issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
        chk("lb_u", bus.rsp_rdata, 32'h0000_00AB);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("lw_merge", bus.rsp_rdata, 32'h1122_AB44);

        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_8001);
        issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        chk("lh_s", bus.rsp_rdata, 32'hFFFF_8001);
        issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        chk("lh_u", bus.rsp_rdata, 32'h0000_8001);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        chk("lw_half", bus.rsp_rdata, 32'h8001_0000);

        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        chk("mis_adel",  bus.rsp_adel, 1);
        chk("mis_ades",  bus.rsp_ades, 0);
        chk("mis_rdata", bus.rsp_rdata, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h5, 32'hCAFE_F00D);
        chk("sw_mis_ades", bus.rsp_ades, 1);
        chk("sw_mis_adel", bus.rsp_adel, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        chk("no_write", bus.rsp_rdata, 32'h8001_0000);
        chk("no_write_adel", bus.rsp_adel, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        chk("oor_adel", bus.rsp_adel, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h55);
        chk("oor_ades", bus.rsp_ades, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        chk("sz11_adel", bus.rsp_adel, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h7, 32'h0);
        chk("lh_odd_adel", bus.rsp_adel, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        chk("last_word_ok", bus.rsp_adel, 0);

        idle();
        chk("idle_valid", bus.rsp_valid, 0);
        chk("idle_rdata", bus.rsp_rdata, 0);
        chk("idle_adel",  bus.rsp_adel, 0);

        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
        chk("b2b_ack", bus.rsp_valid, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("b2b_valid", bus.rsp_valid, 1);
        chk("b2b_raw",   bus.rsp_rdata, 32'hDEAD_BEEF);

        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        bus.req_valid = 1'b0;
        chk("pend_rdata", bus.rsp_rdata, 32'h1122_AB44);
        reset = 1'b0;
        #1;
        chk("midrst_valid", bus.rsp_valid, 0);
        chk("midrst_rdata", bus.rsp_rdata, 0);
        chk("midrst_busy",  init_busy, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        count_sweep("sweep2");
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("wiped_8", bus.rsp_rdata, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("wiped_0", bus.rsp_rdata, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_bytectl.md
Name: dm_bytectl

Overview:
Parametrised successor data memory for the MIPS pipeline MEM stage. Supports byte, halfword and word loads and stores, with optional sign extension on loads. Read data is registered, so responses arrive one cycle after the request. Detects misaligned and out-of-range accesses and raises AdEL/AdES. After reset, a sweep FSM zeroes the whole array one word per cycle.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words in the array (any value >= 2).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.
IDX_W, $clog2(DEPTH_WORDS), width of the word index and of the sweep counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  access request this cycle
req_ready  out  1  high only in RUN state; a request is accepted when req_valid && req_ready at a rising edge
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
req_signed  in  1  sign-extend sub-word loads when 1, zero-extend when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_pc  in  32  PC of the instruction, used only for trace
rsp_valid  out  1  one-cycle pulse, exactly one per accepted request
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_adel  out  1  load fault, valid with rsp_valid
rsp_ades  out  1  store fault, valid with rsp_valid
init_busy  out  1  high while the CLEAR sweep runs

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR and the sweep counter goes to 0.
  - rsp_valid, rsp_rdata, rsp_adel and rsp_ades go to 0; init_busy goes to 1.
  - Reset mid-operation discards any in-flight response and restarts the sweep.
- CLEAR state:
  - Each cycle writes 0 to word[cnt], then increments cnt.
  - The last write is at cnt = DEPTH_WORDS-1; the next state is RUN.
  - The sweep takes exactly DEPTH_WORDS cycles after reset deasserts. req_ready=0 throughout.
- RUN state:
  - req_ready=1 and init_busy=0. RUN has no exit other than reset.
- Fault check on the accepted request (combinational on the request):
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - Out of range: addr < BASE_ADDR, or addr-BASE_ADDR >= DEPTH_WORDS*4.
  - Any fault sets rsp_adel if it is a load, rsp_ades if it is a store. The other flag stays 0.
  - A faulting store never modifies the array.
- Stores:
  - Lanes are little-endian; word index = (addr-BASE_ADDR)>>2.
  - Byte writes lane addr[1:0]. Half writes lanes {addr[1],0} and {addr[1],1}. Word writes all 4 lanes.
  - Unselected lanes are preserved. The write takes effect at the accepting edge.
- Loads:
  - The selected lane(s) are read at the accepting edge and extended per req_signed.
  - The result is registered to rsp_rdata, with rsp_valid=1 in the following cycle.
- Latency and throughput:
  - Latency is 1 cycle for both loads and stores; stores also pulse rsp_valid (ack).
  - Back-to-back requests are allowed, one per cycle.
  - A load accepted the cycle after a store to the same word returns the updated data (read-after-write visible).
- Idle cycles: with no accepted request, rsp_valid=0 and rsp_rdata/rsp_adel/rsp_ades return to 0.

Optional Feature:
DM_TRACE_EN
- Defined: each non-faulting store prints "@%h: *%h <= %h" via $display at the writing edge. Fields are req_pc, the word-aligned byte address, and the full merged 32-bit word after the write. The CLEAR sweep does not print.
- Undefined: no display code is compiled; functional behaviour is identical.

Test Plan:
- Reset release with DEPTH_WORDS=16 -> init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. Loading any word afterwards returns 0.
- Word store 0x11223344 @0x8, then byte store 0xAB @0x9, then signed byte load @0x9 -> rsp_rdata=0xFFFFFFAB. An unsigned word load @0x8 -> 0x1122AB44.
- Half store 0x8001 @0x6, then signed half load @0x6 -> 0xFFFF8001. An unsigned half load -> 0x00008001.
- Word load @0x2 -> rsp_adel=1 and rsp_ades=0. Word store @0x5 -> rsp_ades=1, and a later load @0x4 shows the old value. Load @BASE+DEPTH_WORDS*4 -> rsp_adel=1.
- Back-to-back: store 0xDEADBEEF @0x0 at cycle N, load @0x0 at N+1 -> rsp_valid at N+1 and N+2; rsp_rdata=0xDEADBEEF at N+2.
- Assert reset while a load response is pending -> rsp_valid drops immediately; a full CLEAR sweep reruns; earlier data reads 0 afterwards.
